ab_search_array: RTL and testbench
==================================

# ab_search_array

Parametrised, multi-lane successor to the `searchUnit` a/b testing block. It loads a multi-word seed state `S` and a candidate limit `L`, then tests `LANES` consecutive candidates per clock against a masked target. It reports the lowest-index matching candidate, or exhaustion, with a held `finish` level that the search controller and benches sample on its rising edge.

## Interface
- `WORDS`, 4: number of 32-bit words in a state; state width `SW = 32*WORDS`.
- `LANES`, 2: candidates tested per cycle; legal values are 1 to 8.
- `clk` in 1: clock, rising-edge active.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start` in 1: begin a search; sampled at a rising edge in IDLE or DONE.
- `S` in SW: seed state; word 0 (`S[31:0]`) is least significant.
- `L` in 32: number of candidates to test.
- `target` in SW: match pattern.
- `mask` in SW: a 1 bit marks a compared position.
- `outS` out SW: result state.
- `found` out 1: a match occurred.
- `tested` out 32: number of candidates examined.
- `busy` out 1: high in RUN.
- `finish` out 1: high in DONE.

## Operation
- **Candidate definition:** candidate k is `c_k = (S + k) mod 2^SW`, using a full-width add with carry across words.
- **Match rule:** `((c_k ^ target) & mask) == 0`. When `mask = 0`, every candidate matches.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE/DONE on `start`:**
  - latch `S`, `target` and `mask`;
  - set `base = S` and `remaining = L`;
  - clear `found`, `tested` and `outS`;
  - go to RUN.
- **Other inputs:** ignored after they are latched. `start` is ignored in RUN.
- **RUN, each cycle:** evaluate lanes j = 0..LANES-1. Lane j is valid only if `j < remaining`, and it tests `base + j`.
  - **`remaining == 0`:** go to DONE with `found = 0`, `outS = base`, `tested` unchanged.
  - **Any valid lane matches:** take the lowest such j. Set `outS = base + j`, `found = 1`, `tested += j + 1`, then go to DONE.
  - **No match and `remaining <= LANES`:** set `tested += remaining`, `outS = base + remaining` (equal to `S + L`, wrapped), `found = 0`, then go to DONE.
  - **No match otherwise:** `base += LANES`, `remaining -= LANES`, `tested += LANES`, stay in RUN.
- **DONE:** `finish` and the results are held until the next `start` or `reset`.
- **Restart from DONE:** a `start` in DONE restarts the search.

## Timing
- **Reset values:** on `reset` (asynchronous, at any time including mid-RUN):
  - state = IDLE;
  - `outS = 0`, `found = 0`, `tested = 0`, `busy = 0`, `finish = 0`;
  - internal `base` and `remaining` = 0.
- **Exit from reset:** the first active edge after `reset` deasserts may sample `start`.
- **Start to RUN:** `start` sampled at edge 0 makes RUN, with `busy = 1` and `finish = 0`, after edge 0.
- **Match latency:** a match at index k raises `finish` after edge `floor(k/LANES) + 1`.
- **Exhaustion latency:** for L > 0, `finish` rises after edge `ceil(L/LANES)`. For L = 0, it rises after edge 1.
- **Output consistency:** `outS`, `found` and `tested` are valid in the same cycle `finish` rises, and stay stable while in DONE.
- **Restart timing:** `start` in DONE drops `finish` and clears `found`/`tested`/`outS` after that same edge.
- **Counter width:** `remaining` and `tested` are 32 bits. The lane adder is SW bits and wraps silently.
- **Pipelining:** fully combinational lane compare; no pipelining. Throughput is LANES candidates per cycle.

## Test plan
- **Single candidate:** `WORDS=4`, `LANES=2`, `S=2`, `L=1`, `target=2`, `mask` all ones, start at edge 0.
  - `finish` after edge 1, `found=1`, `outS=2`, `tested=1`.
- **Mid-search match:** `S=2`, `L=10`, `target=7`, `mask` all ones.
  - k=5, so `finish` after edge 3, `found=1`, `outS=7`, `tested=6`.
- **Exhaustion, L odd:** `S=2`, `L=5`, `target=100`.
  - `finish` after edge 3, `found=0`, `outS=7`, `tested=5`.
- **L = 0:** `L=0`, any seed.
  - `finish` after edge 1, `found=0`, `outS=S`, `tested=0`.
- **Wrap-around and partial mask:** `S` all ones, `L=4`, `target=1`, `mask=0x...0000000F`.
  - Candidates all ones, 0, 1, so k=2, `outS=1`, `found=1`, `tested=3`, `finish` after edge 2.
- **Control hazards, run as one sequence:**
  - `start` re-pulsed during RUN: no effect.
  - `reset` asserted mid-RUN: all outputs 0 immediately.
  - Afterwards, restart with `S=3`, `L=10`, `target=3`: `finish` after edge 1, `outS=3`.
  - `start` again from DONE: `finish` drops and the search reruns.
  - Repeat the "Mid-search match" case with `LANES=1`: `finish` after edge 6.

Source files
------------

// File: rtl/ab_search_array.sv
// Multi-lane a/b search: tests LANES consecutive candidates (seed + k) per clock
// against a masked target and reports the lowest matching index or exhaustion.
module ab_search_array #(
    parameter int WORDS = 4,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   S,
    input  logic [31:0]           L,
    input  logic [32*WORDS-1:0]   target,
    input  logic [32*WORDS-1:0]   mask,
    output logic [32*WORDS-1:0]   outS,
    output logic                  found,
    output logic [31:0]           tested,
    output logic                  busy,
    output logic                  finish
);

    localparam int SW = 32 * WORDS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] LANES32 = 32'(LANES);

    logic [1:0]    r_state;
    logic [SW-1:0] r_base;
    logic [31:0]   r_remaining;
    logic [SW-1:0] r_target;
    logic [SW-1:0] r_mask;
    logic [SW-1:0] r_outS;
    logic          r_found;
    logic [31:0]   r_tested;

    logic [SW-1:0]    w_cand [LANES];
    logic [LANES-1:0] w_match;
    logic             w_hit;
    logic [31:0]      w_hitIdx;
    logic [SW-1:0]    w_hitState;
    logic [SW-1:0]    w_endState;

    // Lanes beyond the remaining count are masked off so a short tail never over-reports.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_cand[j]  = r_base + SW'(j);
        assign w_match[j] = (32'(j) < r_remaining) &&
                            (((w_cand[j] ^ r_target) & r_mask) == '0);
    end

    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (w_match[j]) begin
                w_hit    = 1'b1;
                w_hitIdx = 32'(j);
            end
        end
    end

    assign w_hitState = r_base + SW'(w_hitIdx);
    assign w_endState = r_base + SW'(r_remaining);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_remaining <= '0;
            r_target    <= '0;
            r_mask      <= '0;
            r_outS      <= '0;
            r_found     <= 1'b0;
            r_tested    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_base      <= S;
                        r_remaining <= L;
                        r_target    <= target;
                        r_mask      <= mask;
                        r_outS      <= '0;
                        r_found     <= 1'b0;
                        r_tested    <= '0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_remaining == '0) begin
                        r_outS  <= r_base;
                        r_found <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_hit) begin
                        r_outS   <= w_hitState;
                        r_found  <= 1'b1;
                        r_tested <= r_tested + w_hitIdx + 32'd1;
                        r_state  <= ST_DONE;
                    end else if (r_remaining <= LANES32) begin
                        r_outS   <= w_endState;
                        r_found  <= 1'b0;
                        r_tested <= r_tested + r_remaining;
                        r_state  <= ST_DONE;
                    end else begin
                        r_base      <= r_base + SW'(LANES);
                        r_remaining <= r_remaining - LANES32;
                        r_tested    <= r_tested + LANES32;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign outS   = r_outS;
    assign found  = r_found;
    assign tested = r_tested;
    assign busy   = (r_state == ST_RUN);
    assign finish = (r_state == ST_DONE);

endmodule

// File: tb/tb_ab_search_array.sv
// Directed bench for ab_search_array: a 2-lane and a 1-lane instance share stimulus;
// each scenario task checks finish latency and result values inline.
module tb_ab_search_array;

    localparam int WORDS = 4;
    localparam int SW    = 32 * WORDS;

    logic          clk;
    logic          reset;
    logic          start;
    logic [SW-1:0] S;
    logic [31:0]   L;
    logic [SW-1:0] target;
    logic [SW-1:0] mask;

    logic [SW-1:0] outS,   outS1;
    logic          found,  found1;
    logic [31:0]   tested, tested1;
    logic          busy,   busy1;
    logic          finish, finish1;

    logic [SW-1:0] allOnes;
    int            passCount;
    int            totalCount;

    ab_search_array #(.WORDS(WORDS), .LANES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .S(S), .L(L),
        .target(target), .mask(mask), .outS(outS), .found(found),
        .tested(tested), .busy(busy), .finish(finish)
    );

    ab_search_array #(.WORDS(WORDS), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .S(S), .L(L),
        .target(target), .mask(mask), .outS(outS1), .found(found1),
        .tested(tested1), .busy(busy1), .finish(finish1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start across one rising edge (edge 0); returns at the following falling edge.
    task automatic doStart(input logic [SW-1:0] s, input logic [31:0] l,
                           input logic [SW-1:0] t, input logic [SW-1:0] m);
        @(negedge clk);
        S      = s;
        L      = l;
        target = t;
        mask   = m;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts rising edges until finish is seen; -1 if the budget expires.
    task automatic waitFinish(input bit useOne, output int edges);
        edges = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((useOne ? finish1 : finish) === 1'b1) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        totalCount++; if (outS !== '0) $display("[TB] FAIL reset_outS: got %h expected 0", outS); else passCount++;
        totalCount++; if (found !== 1'b0) $display("[TB] FAIL reset_found: got %b expected 0", found); else passCount++;
        totalCount++; if (tested !== 32'd0) $display("[TB] FAIL reset_tested: got %0d expected 0", tested); else passCount++;
        totalCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        totalCount++; if (finish !== 1'b0) $display("[TB] FAIL reset_finish: got %b expected 0", finish); else passCount++;
    endtask

    task automatic test_single();
        int e;
        doStart(128'd2, 32'd1, 128'd2, allOnes);
        totalCount++; if (busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", busy); else passCount++;
        waitFinish(1'b0, e);
        totalCount++; if (e !== 1) $display("[TB] FAIL single_latency: got %0d expected 1", e); else passCount++;
        totalCount++; if (found !== 1'b1) $display("[TB] FAIL single_found: got %b expected 1", found); else passCount++;
        totalCount++; if (outS !== 128'd2) $display("[TB] FAIL single_outS: got %h expected 2", outS); else passCount++;
        totalCount++; if (tested !== 32'd1) $display("[TB] FAIL single_tested: got %0d expected 1", tested); else passCount++;
    endtask

    task automatic test_mid_search();
        int e;
        doStart(128'd2, 32'd10, 128'd7, allOnes);
        waitFinish(1'b0, e);
        totalCount++; if (e !== 3) $display("[TB] FAIL mid_latency: got %0d expected 3", e); else passCount++;
        totalCount++; if (found !== 1'b1) $display("[TB] FAIL mid_found: got %b expected 1", found); else passCount++;
        totalCount++; if (outS !== 128'd7) $display("[TB] FAIL mid_outS: got %h expected 7", outS); else passCount++;
        totalCount++; if (tested !== 32'd6) $display("[TB] FAIL mid_tested: got %0d expected 6", tested); else passCount++;
        @(negedge clk);
        totalCount++; if (finish !== 1'b1 || outS !== 128'd7) $display("[TB] FAIL mid_hold: got finish=%b outS=%h expected 1/7", finish, outS); else passCount++;
    endtask

    task automatic test_exhaust_odd();
        int e;
        doStart(128'd2, 32'd5, 128'd100, allOnes);
        waitFinish(1'b0, e);
        totalCount++; if (e !== 3) $display("[TB] FAIL exh_latency: got %0d expected 3", e); else passCount++;
        totalCount++; if (found !== 1'b0) $display("[TB] FAIL exh_found: got %b expected 0", found); else passCount++;
        totalCount++; if (outS !== 128'd7) $display("[TB] FAIL exh_outS: got %h expected 7", outS); else passCount++;
        totalCount++; if (tested !== 32'd5) $display("[TB] FAIL exh_tested: got %0d expected 5", tested); else passCount++;
    endtask

    task automatic test_zero_len();
        int e;
        doStart(128'h1234_5678_9abc, 32'd0, 128'h1234_5678_9abc, allOnes);
        waitFinish(1'b0, e);
        totalCount++; if (e !== 1) $display("[TB] FAIL zero_latency: got %0d expected 1", e); else passCount++;
        totalCount++; if (found !== 1'b0) $display("[TB] FAIL zero_found: got %b expected 0", found); else passCount++;
        totalCount++; if (outS !== 128'h1234_5678_9abc) $display("[TB] FAIL zero_outS: got %h expected 123456789abc", outS); else passCount++;
        totalCount++; if (tested !== 32'd0) $display("[TB] FAIL zero_tested: got %0d expected 0", tested); else passCount++;
    endtask

    task automatic test_wrap_mask();
        int e;
        doStart(allOnes, 32'd4, 128'd1, 128'hF);
        waitFinish(1'b0, e);
        totalCount++; if (e !== 2) $display("[TB] FAIL wrap_latency: got %0d expected 2", e); else passCount++;
        totalCount++; if (found !== 1'b1) $display("[TB] FAIL wrap_found: got %b expected 1", found); else passCount++;
        totalCount++; if (outS !== 128'd1) $display("[TB] FAIL wrap_outS: got %h expected 1", outS); else passCount++;
        totalCount++; if (tested !== 32'd3) $display("[TB] FAIL wrap_tested: got %0d expected 3", tested); else passCount++;
    endtask

    task automatic test_start_in_run();
        int e;
        doStart(128'd2, 32'd10, 128'd7, allOnes);
        @(posedge clk);
        @(negedge clk);
        S      = 128'd100;
        target = 128'd101;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        totalCount++; if (busy !== 1'b1 || finish !== 1'b0) $display("[TB] FAIL rerun_state: got busy=%b finish=%b expected 1/0", busy, finish); else passCount++;
        waitFinish(1'b0, e);
        totalCount++; if (e !== 1) $display("[TB] FAIL rerun_latency: got %0d expected 1 more edge", e); else passCount++;
        totalCount++; if (outS !== 128'd7 || tested !== 32'd6) $display("[TB] FAIL rerun_result: got outS=%h tested=%0d expected 7/6", outS, tested); else passCount++;
    endtask

    task automatic test_reset_mid_run();
        doStart(128'd2, 32'd20, 128'd1000, allOnes);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        totalCount++; if (tested !== 32'd4 || busy !== 1'b1) $display("[TB] FAIL prereset: got tested=%0d busy=%b expected 4/1", tested, busy); else passCount++;
        #1 reset = 1'b1;
        #1;
        totalCount++; if (outS !== '0 || found !== 1'b0 || tested !== 32'd0 || busy !== 1'b0 || finish !== 1'b0)
            $display("[TB] FAIL async_reset: got outS=%h found=%b tested=%0d busy=%b finish=%b expected all 0", outS, found, tested, busy, finish);
        else passCount++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_restart_from_done();
        int e;
        doStart(128'd3, 32'd10, 128'd3, allOnes);
        waitFinish(1'b0, e);
        totalCount++; if (e !== 1) $display("[TB] FAIL restart_latency: got %0d expected 1", e); else passCount++;
        totalCount++; if (outS !== 128'd3 || found !== 1'b1 || tested !== 32'd1) $display("[TB] FAIL restart_result: got outS=%h found=%b tested=%0d expected 3/1/1", outS, found, tested); else passCount++;
        doStart(128'd3, 32'd10, 128'd3, allOnes);
        totalCount++; if (finish !== 1'b0 || busy !== 1'b1 || found !== 1'b0 || tested !== 32'd0 || outS !== '0)
            $display("[TB] FAIL restart_clear: got finish=%b busy=%b found=%b tested=%0d outS=%h expected 0/1/0/0/0", finish, busy, found, tested, outS);
        else passCount++;
        waitFinish(1'b0, e);
        totalCount++; if (e !== 1 || outS !== 128'd3) $display("[TB] FAIL rerun_done: got edges=%0d outS=%h expected 1/3", e, outS); else passCount++;
    endtask

    task automatic test_lanes1();
        int e;
        doStart(128'd2, 32'd10, 128'd7, allOnes);
        waitFinish(1'b1, e);
        totalCount++; if (e !== 6) $display("[TB] FAIL lanes1_latency: got %0d expected 6", e); else passCount++;
        totalCount++; if (found1 !== 1'b1 || outS1 !== 128'd7 || tested1 !== 32'd6) $display("[TB] FAIL lanes1_result: got found=%b outS=%h tested=%0d expected 1/7/6", found1, outS1, tested1); else passCount++;
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        allOnes    = '1;
        reset      = 1'b1;
        start      = 1'b0;
        S          = '0;
        L          = '0;
        target     = '0;
        mask       = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_single();
        test_mid_search();
        test_exhaust_odd();
        test_zero_len();
        test_wrap_mask();
        test_start_in_run();
        test_reset_mid_run();
        test_restart_from_done();
        test_lanes1();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
